regfile_wb_arbiter: RTL and testbench

Write-port scheduler for the multicycle processor's 64-entry register file. It accepts writeback requests from two producers: A (ALU/writeback FSM) and B (load unit). Only one request is granted per cycle, chosen round-robin, and the granted request drives the register file's single write port (rd, wd3, regwrite) through a registered stage. It also keeps a pending-write scoreboard that the decode stage queries to stall on read-after-write hazards.

---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port scheduler for the 64-entry register file.
// Round-robin A/B grant, registered issue stage, pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int NREG           = 64,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_rd,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wd3,
  output logic              regwrite
);

  typedef enum logic {
    FAV_A = 1'b0,
    FAV_B = 1'b1
  } rr_t;

  rr_t               rr_q;
  rr_t               rr_d;
  logic              grant_a;
  logic              grant_b;
  logic              grant;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic              win_zero;
  logic              claim_zero;
  logic              issue;
  logic [NREG-1:0]   sb_q;
  logic [NREG-1:0]   sb_d;

  // Grant one requester; the pointer only breaks ties.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      if (a_valid && (!b_valid || rr_q == FAV_A)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign grant   = grant_a | grant_b;
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Select the winner's payload and detect discarded x0 writes.
  always_comb begin
    win_rd     = a_rd;
    win_data   = a_data;
    if (grant_b) begin
      win_rd   = b_rd;
      win_data = b_data;
    end
    win_zero   = (ZERO_HARDWIRED != 0) && (win_rd == '0);
    claim_zero = (ZERO_HARDWIRED != 0) && (claim_rd == '0);
    issue      = grant && !win_zero;
  end

  // Pointer moves to the other requester after every grant.
  always_comb begin
    rr_d = rr_q;
    if (grant_a) rr_d = FAV_B;
    if (grant_b) rr_d = FAV_A;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= FAV_A;
    else        rr_q <= rr_d;
  end

  // Issue stage: rd/wd3 hold when nothing is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite <= 1'b0;
      rd       <= '0;
      wd3      <= '0;
    end else begin
      regwrite <= issue;
      if (issue) begin
        rd  <= win_rd;
        wd3 <= win_data;
      end
    end
  end

  // Clear on commit, then set on claim so a same-edge claim wins.
  always_comb begin
    sb_d = sb_q;
    if (regwrite) sb_d[rd] = 1'b0;
    if (claim_valid && !claim_zero) sb_d[claim_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign q_busy1 = sb_q[q_rs1];
  assign q_busy2 = sb_q[q_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Includes a behavioural reg_file to observe committed data.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [5:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [5:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        claim_valid;
  logic [5:0]  claim_rd;
  logic [5:0]  q_rs1;
  logic [5:0]  q_rs2;
  logic        q_busy1;
  logic        q_busy2;
  logic [5:0]  rd;
  logic [31:0] wd3;
  logic        regwrite;

  logic [31:0] mem [64];

  int checks;
  int failures;

  regfile_wb_arbiter #(
    .ADDR_W(6), .DATA_W(32), .NREG(64), .ZERO_HARDWIRED(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .claim_valid(claim_valid), .claim_rd(claim_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .q_busy1(q_busy1), .q_busy2(q_busy2),
    .rd(rd), .wd3(wd3), .regwrite(regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (regwrite) mem[rd] <= wd3;
  end

  task automatic idle();
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    claim_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b1; a_rd = 6'd4; a_data = 32'h1;
    b_valid = 1'b1; b_rd = 6'd5; b_data = 32'h2;
    claim_valid = 1'b0; claim_rd = '0;
    q_rs1 = 6'd4; q_rs2 = 6'd5;
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b%b exp=00", a_ready, b_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b0 || rd !== 6'd0 || wd3 !== 32'd0) begin
      failures++;
      $display("FAIL rst_outs got=%b/%0d/%h exp=0/0/0", regwrite, rd, wd3);
    end
    checks++;
    if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got=%b%b exp=00", q_busy1, q_busy2);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 6'd20; a_data = 32'h12345678;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready got=%b%b exp=10", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b1 || rd !== 6'd20 || wd3 !== 32'h12345678) begin
      failures++;
      $display("FAIL single_issue got=%b/%0d/%h exp=1/20/12345678",
               regwrite, rd, wd3);
    end
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b0 || mem[20] !== 32'h12345678) begin
      failures++;
      $display("FAIL single_commit got=%b/%h exp=0/12345678",
               regwrite, mem[20]);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    claim_valid = 1'b1; claim_rd = 6'd18;
    @(negedge clk);
    claim_valid = 1'b0;
    q_rs2 = 6'd18;
    #1;
    checks++;
    if (q_busy2 !== 1'b1) begin
      failures++;
      $display("FAIL sb_claim got=%b exp=1", q_busy2);
    end
    b_valid = 1'b1; b_rd = 6'd18; b_data = 32'h87654321;
    #1;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      failures++;
      $display("FAIL sb_bready got=%b%b exp=01", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b1 || rd !== 6'd18 || q_busy2 !== 1'b1) begin
      failures++;
      $display("FAIL sb_hold got=%b/%0d/%b exp=1/18/1", regwrite, rd, q_busy2);
    end
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    checks++;
    if (q_busy2 !== 1'b0 || mem[18] !== 32'h87654321) begin
      failures++;
      $display("FAIL sb_clear got=%b/%h exp=0/87654321", q_busy2, mem[18]);
    end
  endtask

  task automatic test_alternate();
    logic [31:0] na;
    logic [31:0] nb;
    logic        exp_a;
    na = 32'hA0000000;
    nb = 32'hB0000000;
    @(negedge clk);
    a_valid = 1'b1; a_rd = 6'd5; a_data = na;
    b_valid = 1'b1; b_rd = 6'd6; b_data = nb;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      checks++;
      if (a_ready !== exp_a || b_ready !== !exp_a) begin
        failures++;
        $display("FAIL alt_grant%0d got=%b%b exp=%b%b",
                 i, a_ready, b_ready, exp_a, !exp_a);
      end
      @(posedge clk);
      #1;
      checks++;
      if (regwrite !== 1'b1 || rd !== (exp_a ? 6'd5 : 6'd6) ||
          wd3 !== (exp_a ? na : nb)) begin
        failures++;
        $display("FAIL alt_issue%0d got=%b/%0d/%h exp=1/%0d/%h",
                 i, regwrite, rd, wd3, exp_a ? 5 : 6, exp_a ? na : nb);
      end
      @(negedge clk);
      if (exp_a) begin
        na = na + 32'd1;
        a_data = na;
      end else begin
        nb = nb + 32'd1;
        b_data = nb;
      end
    end
    idle();
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b0 || mem[5] !== 32'hA0000001 ||
        mem[6] !== 32'hB0000001) begin
      failures++;
      $display("FAIL alt_final got=%b/%h/%h exp=0/a0000001/b0000001",
               regwrite, mem[5], mem[6]);
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 6'd0; a_data = 32'hFFFFFFFF;
    claim_valid = 1'b1; claim_rd = 6'd0;
    q_rs1 = 6'd0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ready got=%b exp=1", a_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b0 || q_busy1 !== 1'b0) begin
      failures++;
      $display("FAIL zero_write got=%b/%b exp=0/0", regwrite, q_busy1);
    end
    @(negedge clk);
    idle();
    a_valid = 1'b1; a_rd = 6'd1; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 6'd2; b_data = 32'h22;
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ptr got=%b%b exp=01", a_ready, b_ready);
    end
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic test_claim_clear();
    @(negedge clk);
    claim_valid = 1'b1; claim_rd = 6'd9;
    @(negedge clk);
    claim_valid = 1'b0;
    a_valid = 1'b1; a_rd = 6'd9; a_data = 32'h99;
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b1 || rd !== 6'd9) begin
      failures++;
      $display("FAIL cc_issue got=%b/%0d exp=1/9", regwrite, rd);
    end
    @(negedge clk);
    a_valid = 1'b0;
    claim_valid = 1'b1; claim_rd = 6'd9;
    q_rs1 = 6'd9;
    @(posedge clk);
    #1;
    checks++;
    if (q_busy1 !== 1'b1) begin
      failures++;
      $display("FAIL cc_claim_wins got=%b exp=1", q_busy1);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    claim_valid = 1'b1; claim_rd = 6'd3;
    @(negedge clk);
    claim_rd = 6'd7;
    @(negedge clk);
    claim_valid = 1'b0;
    q_rs1 = 6'd3; q_rs2 = 6'd7;
    b_valid = 1'b1; b_rd = 6'd11; b_data = 32'hBB;
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b1 || q_busy1 !== 1'b1 || q_busy2 !== 1'b1) begin
      failures++;
      $display("FAIL rm_pre got=%b/%b%b exp=1/11", regwrite, q_busy1, q_busy2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b1; a_rd = 6'd12; a_data = 32'hAA;
    b_data = 32'hBC;
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_ready got=%b%b exp=00", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b0 || q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
      failures++;
      $display("FAIL rm_clear got=%b/%b%b exp=0/00", regwrite, q_busy1, q_busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_first got=%b%b exp=10", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regwrite !== 1'b1 || rd !== 6'd12 || wd3 !== 32'hAA) begin
      failures++;
      $display("FAIL rm_issue got=%b/%0d/%h exp=1/12/aa", regwrite, rd, wd3);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_a();
    test_scoreboard();
    test_alternate();
    test_zero();
    test_claim_clear();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
